nexys_starship_monster_ctrl: RTL

- Downstream consumer of the PRNG stage's per-direction monster flags (top/btm/left/right random).
- Turns those per-clock random flags into per-direction monster lifecycles: spawn, age, kill, cooldown and escape.
- Drives the monster-present indicators, the kill score and the game-over flag used by the display and top-level game FSM.

---
 rtl/nexys_starship_monster_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/nexys_starship_monster_ctrl.sv
// Per-direction monster lifecycle controller: turns PRNG spawn flags into
// spawn/age/kill/cooldown/escape behaviour, a saturating kill score and a game-over latch.
module nexys_starship_monster_ctrl #(
    parameter int LIFETIME   = 8,
    parameter int COOLDOWN   = 2,
    parameter int MAX_ACTIVE = 2,
    parameter int SCORE_W    = 8
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               clear,
    input  logic               game_en,
    input  logic               tick,
    input  logic [3:0]         spawn_req,
    input  logic [3:0]         kill,
    output logic [3:0]         monster_on,
    output logic [3:0]         escape_dir,
    output logic [SCORE_W-1:0] score,
    output logic               game_over
);

    localparam int AGE_W = (LIFETIME > 1) ? $clog2(LIFETIME) : 1;
    localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ALIVE = 2'd1,
        S_COOL  = 2'd2
    } dir_state_t;

    dir_state_t         st_q  [3:0];
    dir_state_t         st_d  [3:0];
    logic [AGE_W-1:0]   age_q [3:0];
    logic [AGE_W-1:0]   age_d [3:0];
    logic [CD_W-1:0]    cd_q  [3:0];
    logic [CD_W-1:0]    cd_d  [3:0];
    logic [3:0]         on_d;
    logic [3:0]         esc_d;
    logic [SCORE_W-1:0] score_d;
    logic               over_d;
    logic [SCORE_W+2:0] score_sum;
    int                 alive_cnt;
    int                 granted;
    int                 kill_cnt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < 4; i++) begin
                st_q[i]  <= S_EMPTY;
                age_q[i] <= '0;
                cd_q[i]  <= '0;
            end
            monster_on <= '0;
            escape_dir <= '0;
            score      <= '0;
            game_over  <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                st_q[i]  <= st_d[i];
                age_q[i] <= age_d[i];
                cd_q[i]  <= cd_d[i];
            end
            monster_on <= on_d;
            escape_dir <= esc_d;
            score      <= score_d;
            game_over  <= over_d;
        end
    end

    always_comb begin
        st_d      = st_q;
        age_d     = age_q;
        cd_d      = cd_q;
        on_d      = monster_on;
        esc_d     = escape_dir;
        score_d   = score;
        over_d    = game_over;
        score_sum = '0;
        alive_cnt = 0;
        granted   = 0;
        kill_cnt  = 0;

        // Spawn budget is based on the population at the start of the cycle,
        // so a kill in this cycle does not free a slot until the next one.
        for (int i = 0; i < 4; i++) begin
            if (st_q[i] == S_ALIVE) alive_cnt++;
        end

        if (clear) begin
            for (int i = 0; i < 4; i++) begin
                st_d[i]  = S_EMPTY;
                age_d[i] = '0;
                cd_d[i]  = '0;
            end
            on_d    = '0;
            esc_d   = '0;
            score_d = '0;
            over_d  = 1'b0;
        end else if (game_en && !game_over) begin
            // Walk top (3) down to right (0) so grants follow priority order.
            for (int i = 3; i >= 0; i--) begin
                case (st_q[i])
                    S_EMPTY: begin
                        if (tick && spawn_req[i] && (granted < MAX_ACTIVE - alive_cnt)) begin
                            st_d[i]  = S_ALIVE;
                            age_d[i] = '0;
                            on_d[i]  = 1'b1;
                            granted++;
                        end
                    end
                    S_ALIVE: begin
                        if (kill[i]) begin
                            kill_cnt++;
                            on_d[i] = 1'b0;
                            if (COOLDOWN == 0) begin
                                st_d[i] = S_EMPTY;
                            end else begin
                                st_d[i] = S_COOL;
                                cd_d[i] = CD_W'(COOLDOWN);
                            end
                        end else if (tick) begin
                            if (age_q[i] == AGE_W'(LIFETIME - 1)) begin
                                over_d   = 1'b1;
                                esc_d[i] = 1'b1;
                            end else begin
                                age_d[i] = age_q[i] + 1'b1;
                            end
                        end
                    end
                    S_COOL: begin
                        if (tick) begin
                            if (cd_q[i] == CD_W'(1)) st_d[i] = S_EMPTY;
                            else                     cd_d[i] = cd_q[i] - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            score_sum = (SCORE_W + 3)'(score) + (SCORE_W + 3)'(kill_cnt);
            if (|score_sum[SCORE_W+2:SCORE_W]) score_d = '1;
            else                               score_d = score_sum[SCORE_W-1:0];
        end
    end

endmodule
